pwm_rgb_decoder: RTL and testbench



---
 rtl/pwm_rgb_pkg.sv | 17 +
 rtl/pwm_channel_meter.sv | 129 ++++++++++++
 rtl/pwm_rgb_decoder.sv | 72 +++++++
 tb/tb_pwm_rgb_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_rgb_pkg.sv
// Shared types and helpers for the RGB PWM receive-side measurement blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pwm_rgb_pkg;

  // Per-channel measurement FSM. IDLE waits for an arming rise; MEASURE times periods.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_t;

  // Pin level that means "LED off". Synchronizers and the previous-sample flop reset to it.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/pwm_channel_meter.sv
// Measures one PWM line: active cycles and period per rise-to-rise interval, plus stuck-line timeout.
// Latency: valid on the 3rd rising clk edge after the first edge that samples a new pin level.
// Backpressure: none; results are one-cycle strobes and the output registers hold between strobes.
module pwm_channel_meter
  import pwm_rgb_pkg::*;
#(
  parameter int MAX_PERIOD = 1024,
  parameter int CNT_W      = $clog2(MAX_PERIOD + 1),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pin,
  output logic [CNT_W-1:0] o_high,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_stuck
);

  localparam logic             L_INACT = inactive_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  meas_state_t      r_state;
  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_stuck;

  logic             w_act;
  logic             w_act_prev;
  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;
  logic [CNT_W-1:0] w_timeout_high;

  // Pin levels are normalised so that 1 always means "LED lit".
  assign w_act      = r_sync2 ^ ACTIVE_LOW;
  assign w_act_prev = r_prev ^ ACTIVE_LOW;
  assign w_rise     = w_act & ~w_act_prev;

  // The counter never holds MAX_PERIOD: the cycle that would take it there reports the timeout instead.
  assign w_cnt_next     = r_period_cnt + L_ONE;
  assign w_timeout      = (w_cnt_next == L_MAX);
  assign w_timeout_high = w_act ? L_MAX : '0;

  // Two-flop synchronizer for the asynchronous pin, then one more flop for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= L_INACT;
      r_sync2 <= L_INACT;
      r_prev  <= L_INACT;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Period/active counting FSM; the rise cycle is the first cycle of the new period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_high       <= '0;
      r_period     <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            // First rise only arms: there is no complete period to report yet.
            r_period_cnt <= L_ONE;
            r_high_cnt   <= L_ONE;
            r_state      <= MEASURE;
          end else if (w_timeout) begin
            r_period     <= L_MAX;
            r_high       <= w_timeout_high;
            r_valid      <= 1'b1;
            r_stuck      <= 1'b1;
            r_period_cnt <= '0;
          end else begin
            r_period_cnt <= w_cnt_next;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            r_period     <= r_period_cnt;
            r_high       <= r_high_cnt;
            r_valid      <= 1'b1;
            r_stuck      <= 1'b0;
            r_period_cnt <= L_ONE;
            r_high_cnt   <= L_ONE;
          end else if (w_timeout) begin
            r_period     <= L_MAX;
            r_high       <= w_timeout_high;
            r_valid      <= 1'b1;
            r_stuck      <= 1'b1;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_state      <= IDLE;
          end else begin
            r_period_cnt <= w_cnt_next;
            r_high_cnt   <= r_high_cnt + CNT_W'(w_act);
          end
        end
        default: begin
          r_state      <= IDLE;
          r_period_cnt <= '0;
          r_high_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_high   = r_high;
  assign o_period = r_period;
  assign o_valid  = r_valid;
  assign o_stuck  = r_stuck;

endmodule

// File: rtl/pwm_rgb_decoder.sv
// Receive-side RGB PWM monitor: three independent channel meters for RGB_R/RGB_G/RGB_B.
// Latency: valid on the 3rd rising clk edge after the first edge that samples a new pin level.
// Backpressure: none; per-channel one-cycle strobes, values hold between strobes.
module pwm_rgb_decoder
  import pwm_rgb_pkg::*;
#(
  parameter int MAX_PERIOD = 1024,
  parameter int CNT_W      = $clog2(MAX_PERIOD + 1),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RGB_R,
  input  logic             RGB_G,
  input  logic             RGB_B,
  output logic [CNT_W-1:0] r_high,
  output logic [CNT_W-1:0] g_high,
  output logic [CNT_W-1:0] b_high,
  output logic [CNT_W-1:0] r_period,
  output logic [CNT_W-1:0] g_period,
  output logic [CNT_W-1:0] b_period,
  output logic             r_valid,
  output logic             g_valid,
  output logic             b_valid,
  output logic             r_stuck,
  output logic             g_stuck,
  output logic             b_stuck
);

  pwm_channel_meter #(
    .MAX_PERIOD (MAX_PERIOD),
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_meter_r (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pin    (RGB_R),
    .o_high   (r_high),
    .o_period (r_period),
    .o_valid  (r_valid),
    .o_stuck  (r_stuck)
  );

  pwm_channel_meter #(
    .MAX_PERIOD (MAX_PERIOD),
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_meter_g (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pin    (RGB_G),
    .o_high   (g_high),
    .o_period (g_period),
    .o_valid  (g_valid),
    .o_stuck  (g_stuck)
  );

  pwm_channel_meter #(
    .MAX_PERIOD (MAX_PERIOD),
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_meter_b (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pin    (RGB_B),
    .o_high   (b_high),
    .o_period (b_period),
    .o_valid  (b_valid),
    .o_stuck  (b_stuck)
  );

endmodule

// File: tb/tb_pwm_rgb_decoder.sv
// Bench for pwm_rgb_decoder: directed waveforms plus randomized PWM/toggle stimulus against an interval model.
// Latency: model delays each pin sample by two edges before interpreting it.
// Backpressure: n/a.
module tb_pwm_rgb_decoder;

  localparam int MAXP = 1024;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int HN   = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RGB_R, RGB_G, RGB_B;
  logic [CW-1:0] r_high, g_high, b_high;
  logic [CW-1:0] r_period, g_period, b_period;
  logic          r_valid, g_valid, b_valid;
  logic          r_stuck, g_stuck, b_stuck;

  pwm_rgb_decoder dut (
    .clk(clk), .rst(rst),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
    .r_high(r_high), .g_high(g_high), .b_high(b_high),
    .r_period(r_period), .g_period(g_period), .b_period(b_period),
    .r_valid(r_valid), .g_valid(g_valid), .b_valid(b_valid),
    .r_stuck(r_stuck), .g_stuck(g_stuck), .b_stuck(b_stuck)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- stimulus: per-channel waveform generator ----------------
  // mode 0 = inactive, 1 = held active, 2 = PWM (per/hi), 3 = random level each cycle
  int mode[3];
  int per[3];
  int hi[3];
  int ph[3];

  initial begin
    RGB_R = 1'b1; RGB_G = 1'b1; RGB_B = 1'b1;
    forever begin
      bit act[3];
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        case (mode[c])
          1: act[c] = 1'b1;
          2: begin
            act[c] = (ph[c] < hi[c]);
            ph[c]  = (ph[c] + 1) % per[c];
          end
          3: act[c] = ($urandom_range(0, 1) == 1);
          default: act[c] = 1'b0;
        endcase
      end
      // Active-low pins: lit LED = pin low.
      RGB_R = ~act[0];
      RGB_G = ~act[1];
      RGB_B = ~act[2];
    end
  end

  task automatic set_ch(input int c, input int m, input int p, input int h);
    mode[c] = m;
    per[c]  = (p < 1) ? 1 : p;
    hi[c]   = h;
    ph[c]   = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // A channel is either waiting for an arming rise or timing a period that began at edge 'start'.
  // A report on a rise covers edges [start, t-1]; active cycles are counted from a history log.
  int  t;
  bit  dly0[3], dly1[3], a_prev[3];
  bit  armed[3];
  int  start[3], idle_start[3];
  bit  hist[3][HN];
  int  e_hi[3], e_per[3];
  bit  e_vld[3], e_stk[3];
  int  strobes[3];
  string nm[3] = '{"r", "g", "b"};

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < 3; c++) begin
      dly0[c] = 0; dly1[c] = 0; a_prev[c] = 0;
      armed[c] = 0; start[c] = 0; idle_start[c] = 0;
      e_hi[c] = 0; e_per[c] = 0; e_vld[c] = 0; e_stk[c] = 0;
    end
  endtask

  task automatic model_step(input int c, input bit s);
    bit a_now, rise;
    int sum;
    a_now   = dly1[c];
    dly1[c] = dly0[c];
    dly0[c] = s;
    rise      = a_now & ~a_prev[c];
    a_prev[c] = a_now;
    hist[c][t % HN] = a_now;
    e_vld[c] = 0;
    if (armed[c]) begin
      if (rise) begin
        sum = 0;
        for (int k = start[c]; k < t; k++) sum += int'(hist[c][k % HN]);
        e_per[c] = t - start[c];
        e_hi[c]  = sum;
        e_vld[c] = 1; e_stk[c] = 0;
        start[c] = t;
      end else if (t - start[c] == MAXP - 1) begin
        e_per[c] = MAXP; e_hi[c] = a_now ? MAXP : 0;
        e_vld[c] = 1; e_stk[c] = 1;
        armed[c] = 0; idle_start[c] = t;
      end
    end else begin
      if (rise) begin
        armed[c] = 1; start[c] = t;
      end else if (t - idle_start[c] == MAXP) begin
        e_per[c] = MAXP; e_hi[c] = a_now ? MAXP : 0;
        e_vld[c] = 1; e_stk[c] = 1;
        idle_start[c] = t;
      end
    end
  endtask

  // ---------------- compare process: every cycle, all outputs ----------------
  initial begin
    model_reset();
    forever begin
      bit s[3];
      bit r;
      logic [CW-1:0] dh[3], dp[3];
      logic dv[3], ds[3];
      @(posedge clk);
      s[0] = ~RGB_R; s[1] = ~RGB_G; s[2] = ~RGB_B;
      r = rst;
      #1;
      if (r) model_reset();
      else begin
        t++;
        for (int c = 0; c < 3; c++) model_step(c, s[c]);
      end
      dh = '{r_high, g_high, b_high};
      dp = '{r_period, g_period, b_period};
      dv = '{r_valid, g_valid, b_valid};
      ds = '{r_stuck, g_stuck, b_stuck};
      for (int c = 0; c < 3; c++) begin
        if (dv[c] === 1'b1) strobes[c]++;
        chk({nm[c], "_valid"},  32'(dv[c]), 32'(e_vld[c]));
        chk({nm[c], "_period"}, 32'(dp[c]), e_per[c]);
        chk({nm[c], "_high"},   32'(dh[c]), e_hi[c]);
        chk({nm[c], "_stuck"},  32'(ds[c]), 32'(e_stk[c]));
      end
    end
  end

  task automatic clr_strobes();
    for (int c = 0; c < 3; c++) strobes[c] = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int c = 0; c < 3; c++) set_ch(c, 3, 1, 0);
    // 1: reset held with pins toggling randomly
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_r_period", 32'(r_period), 0);
    chk("rst_g_high",   32'(g_high),   0);
    chk("rst_b_valid",  32'(b_valid),  0);

    // 2: red 100/25, green/blue silent
    for (int c = 0; c < 3; c++) set_ch(c, 0, 1, 0);
    do_reset(2);
    clr_strobes();
    set_ch(0, 2, 100, 25);
    repeat (600) @(posedge clk);
    set_ch(0, 0, 1, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("t2_r_strobes", strobes[0], 5);
    chk("t2_g_strobes", strobes[1], 0);
    chk("t2_b_strobes", strobes[2], 0);
    chk("t2_r_period", 32'(r_period), 100);
    chk("t2_r_high",   32'(r_high),   25);
    chk("t2_r_stuck",  32'(r_stuck),  0);

    // 3: green held active -> single stuck report with full high
    set_ch(1, 1, 1, 0);
    do_reset(2);
    clr_strobes();
    repeat (1100) @(posedge clk);
    set_ch(1, 0, 1, 0);
    repeat (940) @(posedge clk);
    #2;
    chk("t3_g_strobes", strobes[1], 1);
    chk("t3_g_period", 32'(g_period), 1024);
    chk("t3_g_high",   32'(g_high),   1024);
    chk("t3_g_stuck",  32'(g_stuck),  1);

    // 4: identical 50/10 waveform on all three
    do_reset(2);
    clr_strobes();
    for (int c = 0; c < 3; c++) set_ch(c, 2, 50, 10);
    repeat (300) @(posedge clk);
    for (int c = 0; c < 3; c++) set_ch(c, 0, 1, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("t4_r_strobes", strobes[0], 5);
    chk("t4_g_strobes", strobes[1], 5);
    chk("t4_b_strobes", strobes[2], 5);
    chk("t4_b_period", 32'(b_period), 50);
    chk("t4_g_high",   32'(g_high),   10);

    // 5: blue 100/25 with a reset 40 cycles into a measurement
    do_reset(2);
    set_ch(2, 2, 100, 25);
    repeat (240) @(posedge clk);
    do_reset(2);
    #2;
    chk("t5_b_period_clr", 32'(b_period), 0);
    chk("t5_b_high_clr",   32'(b_high),   0);
    clr_strobes();
    repeat (300) @(posedge clk);
    set_ch(2, 0, 1, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("t5_b_strobes", strobes[2], 2);
    chk("t5_b_period", 32'(b_period), 100);
    chk("t5_b_high",   32'(b_high),   25);

    // 6: red 1-cycle pulse every 7, then held inactive into timeout
    do_reset(2);
    clr_strobes();
    set_ch(0, 2, 7, 1);
    repeat (70) @(posedge clk);
    set_ch(0, 0, 1, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("t6_r_strobes", strobes[0], 9);
    chk("t6_r_period", 32'(r_period), 7);
    chk("t6_r_high",   32'(r_high),   1);
    repeat (1100) @(posedge clk);
    #2;
    chk("t6_r_stuck",     32'(r_stuck),  1);
    chk("t6_r_high_idle", 32'(r_high),   0);
    chk("t6_r_period_to", 32'(r_period), 1024);

    // Random: PWM parameters per channel, reconfigured without reset, then random toggling.
    do_reset(2);
    for (int round = 0; round < 3; round++) begin
      for (int c = 0; c < 3; c++) begin
        int p;
        p = $urandom_range(2, 80);
        set_ch(c, 2, p, $urandom_range(1, p - 1));
      end
      repeat (500) @(posedge clk);
    end
    for (int c = 0; c < 3; c++) set_ch(c, 3, 1, 0);
    repeat (300) @(posedge clk);
    set_ch(0, 1, 1, 0);
    set_ch(1, 0, 1, 0);
    set_ch(2, 2, $urandom_range(200, 900), 5);
    repeat (1500) @(posedge clk);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
